mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the multi-cycle CPU datapath. Accepts MULT/MULTU/DIV/DIVU operations on a START pulse, computes one bit per cycle, and holds the result in HI/LO. HI and LO feed data inputs of the write-back 4:1 select mux for MFHI/MFLO. MTHI/MTLO writes also arrive through this block.

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One product/quotient bit per cycle; sign correction and HI/LO write in a final FIX cycle.
module mult_div_unit (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [1:0]  MD_OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MTHI,
    input  logic        MTLO,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div_zero_q, div_zero_d;
    logic [W-1:0]    hi_d, lo_d;
    logic            busy_d, done_d;

    // Operand preparation for an accepted START
    logic            in_signed, in_div, a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;

    // Per-iteration datapath
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic            div_ge;

    // Sign-corrected results
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_fix, rem_fix;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            opnd_q     <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            HI         <= '0;
            LO         <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            opnd_q     <= opnd_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            HI         <= hi_d;
            LO         <= lo_d;
            BUSY       <= busy_d;
            DONE       <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_CALC;
            S_CALC:  if (cnt_q == CW'(W - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        opnd_d     = opnd_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = HI;
        lo_d       = LO;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_q == S_FIX);

        in_signed = ~MD_OP[0];
        in_div    = MD_OP[1];
        a_neg     = in_signed & A[W-1];
        b_neg     = in_signed & B[W-1];
        a_mag     = a_neg ? W'(-A) : A;
        b_mag     = b_neg ? W'(-B) : B;

        // Shift-add: conditionally add multiplicand to the upper half, then shift right
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Restoring divide: shift next dividend bit into the partial remainder and trial-subtract
        div_shift = {rem_q, acc_q[W-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});

        prod_fix  = neg_res_q ? (2*W)'(-acc_q) : acc_q;
        quot_fix  = div_zero_q ? {W{1'b1}} : (neg_res_q ? W'(-acc_q[W-1:0]) : acc_q[W-1:0]);
        rem_fix   = neg_rem_q ? W'(-rem_q) : rem_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d       = MD_OP;
                    cnt_d      = '0;
                    rem_d      = '0;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = in_div & a_neg;
                    div_zero_d = in_div & (B == '0);
                    opnd_d     = in_div ? b_mag : a_mag;
                    acc_d      = {{W{1'b0}}, (in_div ? a_mag : b_mag)};
                end else begin
                    if (MTHI) hi_d = WDATA;
                    if (MTLO) lo_d = WDATA;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q[1]) begin
                    acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};
                    rem_d = div_ge ? W'(div_shift - {1'b0, opnd_q}) : div_shift[W-1:0];
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
            end
            S_FIX: begin
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*W-1:W];
                    lo_d = prod_fix[W-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random-sequence checks for mult_div_unit against hand values and a behavioural model.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] a, b;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .MD_OP (md_op),
        .A     (a),
        .B     (b),
        .MTHI  (mthi),
        .MTLO  (mtlo),
        .WDATA (wdata),
        .BUSY  (busy),
        .DONE  (done),
        .HI    (hi),
        .LO    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural reference: {HI, LO} for a given operation
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = '0;
        case (op)
            2'b00: begin sq = sx * sy; r = sq; end
            2'b01: r = ux * uy;
            2'b10: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Issue one operation from IDLE and wait for DONE; lat counts edges from acceptance (inclusive) to DONE
    task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y, output int lat);
        md_op = op; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; md_op = '0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++; $display("FAIL reset_hilo hi=%h lo=%h expected 0 0", hi, lo);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int lat;
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, lat);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL mult_latency got=%0d expected 34", lat); end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL mult_signed hi=%h lo=%h expected ffffffff fffffffe", hi, lo);
        end
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, lat);
        checks++;
        if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE || lat !== 34) begin
            errors++; $display("FAIL multu hi=%h lo=%h lat=%0d expected 00000001 fffffffe 34", hi, lo, lat);
        end
    endtask

    task automatic test_div();
        int lat;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 34) begin
            errors++; $display("FAIL div_signed hi=%h lo=%h lat=%0d expected ffffffff fffffffd 34", hi, lo, lat);
        end
        run_op(2'b11, 32'd100, 32'd7, lat);
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL divu hi=%h lo=%h expected 00000002 0000000e", hi, lo);
        end
    endtask

    task automatic test_div_edges();
        int lat;
        run_op(2'b11, 32'h1234_5678, 32'd0, lat);
        checks++;
        if ({hi, lo} !== 64'h1234_5678_FFFF_FFFF) begin
            errors++; $display("FAIL divu_by_zero hi=%h lo=%h expected 12345678 ffffffff", hi, lo);
        end
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL div_zero_latency got=%0d expected 34", lat); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            errors++; $display("FAIL div_overflow hi=%h lo=%h expected 00000000 80000000", hi, lo);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, lat);
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFF9_FFFF_FFFF) begin
            errors++; $display("FAIL div_signed_by_zero hi=%h lo=%h expected fffffff9 ffffffff", hi, lo);
        end
    endtask

    task automatic test_ignore_while_busy();
        int n;
        int done_cnt;
        md_op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; md_op = 2'b11; a = 32'd99; b = 32'd4;
        mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        n = 0; done_cnt = 0;
        while (n < 40) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if ({hi, lo} !== {32'd0, 32'd15}) begin
            errors++; $display("FAIL busy_ignore_result hi=%h lo=%h expected 00000000 0000000f", hi, lo);
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL busy_ignore_done_count got=%0d expected 1", done_cnt); end
        mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mtlo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'd0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL mtlo_idle hi=%h lo=%h expected 00000000 deadbeef", hi, lo);
        end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'h0BAD_F00D, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL mt_both hi=%h lo=%h expected 0badf00d 0badf00d", hi, lo);
        end
        start = 1'b1; md_op = 2'b01; a = 32'd6; b = 32'd7; mthi = 1'b1; wdata = 32'h1111_1111;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        checks++;
        if (busy !== 1'b1 || hi !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL start_beats_mt busy=%b hi=%h expected 1 0badf00d", busy, hi);
        end
        n = 1;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if ({hi, lo} !== {32'd0, 32'd42} || n !== 34) begin
            errors++; $display("FAIL start_beats_mt_result hi=%h lo=%h lat=%0d expected 0 0000002a 34", hi, lo, n);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        md_op = 2'b00; a = 32'h0001_2345; b = 32'h0000_0777; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || {hi, lo} !== 64'd0) begin
            errors++; $display("FAIL reset_mid_op busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, lat);
        checks++;
        if ({hi, lo} !== 64'h0000_0001_0000_0000 || lat !== 34) begin
            errors++; $display("FAIL after_reset_op hi=%h lo=%h lat=%0d expected 00000001 00000000 34", hi, lo, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  cop;
        logic [31:0] ca, cb;
        logic [63:0] exp;
        int          n;
        int          sel;
        cop = 2'(($urandom_range(0, 3)));
        ca = $urandom; cb = $urandom;
        md_op = cop; a = ca; b = cb; start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            n = 1;
            while (!done && n < 60) begin @(posedge clk); #1; n++; end
            exp = model(cop, ca, cb);
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL b2b_result op=%0d a=%h b=%h hi=%h lo=%h expected %h %h", cop, ca, cb, hi, lo, exp[63:32], exp[31:0]);
            end
            checks++;
            if (n !== 34) begin errors++; $display("FAIL b2b_interval op=%0d got=%0d expected 34", i, n); end
            if (n >= 60) break;
            if (i < 999) begin
                cop = 2'($urandom_range(0, 3));
                sel = int'($urandom_range(0, 9));
                ca  = (sel == 9) ? 32'h8000_0000 : $urandom;
                case (sel)
                    0:       cb = 32'd0;
                    1:       cb = 32'hFFFF_FFFF;
                    2:       cb = $urandom_range(1, 15);
                    default: cb = $urandom;
                endcase
                md_op = cop; a = ca; b = cb; start = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_edges();
        test_ignore_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
